// File: rtl/led_trail_fader_if.sv
// led_trail_fader_if: pattern/enable inputs and LED drive outputs of the trail fader
interface led_trail_fader_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic [WIDTH-1:0] pattern_in;
    logic [WIDTH-1:0] led_out;
    logic             fading;

    modport master(output enable, pattern_in, input led_out, fading);
    modport slave(input enable, pattern_in, output led_out, fading);
endinterface

// File: rtl/led_trail_fader.sv
// led_trail_fader: PWM comet trail, each LED decays linearly after its pattern bit drops
module led_trail_fader #(
    parameter int WIDTH      = 16,
    parameter int DECAY_DIV  = 256,
    parameter int DECAY_STEP = 16
) (
    input logic               clk,
    input logic               rst,
    led_trail_fader_if.slave  bus
);
    localparam int PW = $clog2(DECAY_DIV);

    logic [WIDTH-1:0]      pat_q, pat_d;
    logic [WIDTH-1:0][7:0] level_q, level_d;
    logic [7:0]            pwm_q, pwm_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [WIDTH-1:0]      led_q, led_d;
    logic                  fading_q, fading_d;
    logic                  tick;

    // next state: counters and levels advance only while enabled, load beats decay
    always_comb begin
        tick     = bus.enable && (presc_q == PW'(DECAY_DIV - 1));
        pat_d    = bus.pattern_in;
        pwm_d    = bus.enable ? pwm_q + 8'd1 : pwm_q;
        presc_d  = bus.enable ? (tick ? '0 : presc_q + 1'b1) : presc_q;
        level_d  = level_q;
        led_d    = '0;
        fading_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.enable)
                level_d[i] = bus.pattern_in[i] ? 8'd255 :
                             tick ? (level_q[i] > 8'(DECAY_STEP) ? level_q[i] - 8'(DECAY_STEP) : 8'd0) :
                             level_q[i];
            led_d[i] = bus.enable && (pat_q[i] || (level_q[i] > pwm_q));
            fading_d = fading_d | (!pat_q[i] && (level_q[i] != 8'd0));
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q    <= '0;
            level_q  <= '0;
            pwm_q    <= '0;
            presc_q  <= '0;
            led_q    <= '0;
            fading_q <= 1'b0;
        end else begin
            pat_q    <= pat_d;
            level_q  <= level_d;
            pwm_q    <= pwm_d;
            presc_q  <= presc_d;
            led_q    <= led_d;
            fading_q <= fading_d;
        end
    end

    assign bus.led_out = led_q;
    assign bus.fading  = fading_q;
endmodule

// File: tb/tb_led_trail_fader.sv
// tb_led_trail_fader: table vectors, reference model with random stimulus, corner sequences
module tb_led_trail_fader;
    localparam int W = 16, DIV = 4, STEP = 64;

    typedef struct {
        logic         r;
        logic         e;
        logic [W-1:0] p;
        logic [W-1:0] led;
        logic         fad;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
    int   checks = 0, errs = 0;
    vec_t tbl[$];

    int           lvl[W];
    int           n;
    logic [W-1:0] mpat, mled;
    logic         mfad;

    always #5 clk = ~clk;

    led_trail_fader_if #(.WIDTH(W)) bus();
    led_trail_fader_if #(.WIDTH(W)) bus2();

    led_trail_fader #(.WIDTH(W), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) dut (.clk(clk), .rst(rst), .bus(bus));
    led_trail_fader #(.WIDTH(W), .DECAY_DIV(1024), .DECAY_STEP(191)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    function automatic void add(logic r, logic e, logic [W-1:0] p, logic [W-1:0] led, logic fad);
        tbl.push_back('{r, e, p, led, fad});
    endfunction

    // reference: n counts enabled cycles since reset; pwm = n mod 256, tick when n mod DIV = DIV-1
    function automatic void model(logic r, logic e, logic [W-1:0] p);
        if (r) begin
            foreach (lvl[i]) lvl[i] = 0;
            n = 0; mpat = '0; mled = '0; mfad = 1'b0;
        end else begin
            mfad = 1'b0;
            for (int i = 0; i < W; i++) begin
                mfad = mfad | (!mpat[i] && lvl[i] != 0);
                mled[i] = e && (mpat[i] || lvl[i] > (n % 256));
            end
            if (e) begin
                for (int i = 0; i < W; i++)
                    if (p[i]) lvl[i] = 255;
                    else if (n % DIV == DIV - 1) lvl[i] = (lvl[i] - STEP < 0) ? 0 : lvl[i] - STEP;
                n++;
            end
            mpat = p;
        end
    endfunction

    task automatic cyc(input logic r, input logic e, input logic [W-1:0] p);
        rst = r; bus.enable = e; bus.pattern_in = p;
        @(posedge clk);
        model(r, e, p);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mchk(input string nm);
        chk({nm, " led"}, 32'(bus.led_out), 32'(mled));
        chk({nm, " fading"}, 32'(bus.fading), 32'(mfad));
    endtask

    initial begin
        int bad, hi, c0, c1, c2;
        logic r, e;
        logic [W-1:0] p;
        bus2.enable = 1'b1; bus2.pattern_in = '0;

        add(1, 1, 16'h0000, 16'h0000, 0);
        add(0, 1, 16'h0001, 16'h0000, 0);
        add(0, 1, 16'h0000, 16'h0001, 0);
        for (int k = 3; k <= 16; k++) add(0, 1, 16'h0000, 16'h0001, 1);
        add(0, 1, 16'h0000, 16'h0000, 0);
        add(0, 1, 16'h0000, 16'h0000, 0);
        foreach (tbl[k]) begin
            cyc(tbl[k].r, tbl[k].e, tbl[k].p);
            chk($sformatf("vec%0d led", k), 32'(bus.led_out), 32'(tbl[k].led));
            chk($sformatf("vec%0d fading", k), 32'(bus.fading), 32'(tbl[k].fad));
        end

        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 399) == 0);
            e = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 7))
                0, 1:    p = 16'h0001 << $urandom_range(0, 15);
                2:       p = 16'($urandom);
                default: p = '0;
            endcase
            cyc(r, e, p);
            mchk($sformatf("rnd%0d", k));
        end

        cyc(1, 1, '0);
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            cyc(0, 1, 16'h8000);
            if (k == 0) chk("hold first edge led", 32'(bus.led_out), 0);
            else if (bus.led_out !== 16'h8000 || bus.fading !== 1'b0) bad++;
        end
        chk("hold 0x8000 bad cycles", 32'(bad), 0);

        cyc(1, 1, '0);
        for (int k = 0; k < 24; k++) begin
            cyc(0, 1, 16'h0001 << (k / 8));
            mchk($sformatf("rot%0d", k));
        end
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(0, 1, '0);
            mchk($sformatf("trail%0d", k));
            c0 += 32'(bus.led_out[0]); c1 += 32'(bus.led_out[1]); c2 += 32'(bus.led_out[2]);
        end
        chk("trail duty bit0<bit1", 32'(c0 < c1), 1);
        chk("trail duty bit1<bit2", 32'(c1 < c2), 1);
        for (int k = 0; k < 6; k++) cyc(0, 1, '0);
        cyc(0, 1, 16'h0004);
        for (int k = 0; k < 24; k++) begin
            cyc(0, 1, '0);
            mchk($sformatf("reload%0d", k));
        end

        cyc(1, 1, '0);
        cyc(0, 1, 16'h00ff);
        for (int k = 0; k < 6; k++) cyc(0, 1, '0);
        chk("pre-reset fading", 32'(bus.fading), 1);
        cyc(1, 1, '0);
        chk("reset mid-fade led", 32'(bus.led_out), 0);
        chk("reset mid-fade fading", 32'(bus.fading), 0);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(0, 1, '0);
            if (bus.led_out !== '0 || bus.fading !== 1'b0) bad++;
        end
        chk("no residual trail", 32'(bad), 0);

        cyc(1, 1, '0);
        cyc(0, 1, 16'h0001);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, '0);
            mchk($sformatf("prepause%0d", k));
        end
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(0, 0, '0);
            if (k > 0 && (bus.led_out !== '0 || bus.fading !== 1'b1)) bad++;
        end
        chk("paused led blank, fading held", 32'(bad), 0);
        for (int k = 0; k < 40; k++) begin
            cyc(0, 1, '0);
            mchk($sformatf("resume%0d", k));
        end

        rst2 = 1'b1;
        cyc(1, 1, '0);
        rst2 = 1'b0; bus2.pattern_in = 16'h0008;
        cyc(1, 1, '0);
        bus2.pattern_in = '0;
        for (int k = 0; k < 1100; k++) cyc(1, 1, '0);
        hi = 0; bad = 0;
        for (int k = 0; k < 256; k++) begin
            cyc(1, 1, '0);
            hi += 32'(bus2.led_out[3]);
            if ((bus2.led_out & ~16'h0008) !== '0) bad++;
        end
        chk("level 64 duty", 32'(hi), 64);
        chk("level 64 other leds", 32'(bad), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
